// File: rtl/segre_pkg.sv
// Shared types and sizes for the segre core memory subsystem.
// Also carries the arbiter FSM/owner encodings and its starvation helper.
package segre_pkg;

    localparam int ADDR_SIZE             = 32;
    localparam int CACHE_LINE_SIZE_BYTES = 16;
    localparam int LINE_W                = CACHE_LINE_SIZE_BYTES * 8;
    localparam int STARVE_W              = 4;

    localparam int GNT_IC_RD = 0;
    localparam int GNT_DC_RD = 1;
    localparam int GNT_DC_WR = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_IC_RD,
        OWN_DC_RD,
        OWN_DC_WR
    } arb_owner_e;

    // Counter only grows while IC is actually waiting behind a DC grant.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic                ic_won,
        input logic                ic_wait,
        input logic [STARVE_W-1:0] limit
    );
        if (ic_won || !ic_wait) begin
            return '0;
        end
        return (cnt == limit) ? cnt : cnt + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/segre_arb_picker.sv
// Combinational priority pick: DC writeback, DC fill, IC fill,
// with IC forced to win once the starvation counter hits its limit.
module segre_arb_picker
    import segre_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                ic_rd_i,
    input  logic                dc_rd_i,
    input  logic                dc_wr_i,
    input  logic [STARVE_W-1:0] starve_cnt_i,
    output logic [2:0]          grant_o
);

    logic starved;

    assign starved = ic_rd_i && (starve_cnt_i == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        grant_o = '0;
        if (starved) begin
            grant_o[GNT_IC_RD] = 1'b1;
        end else if (dc_wr_i) begin
            grant_o[GNT_DC_WR] = 1'b1;
        end else if (dc_rd_i) begin
            grant_o[GNT_DC_RD] = 1'b1;
        end else if (ic_rd_i) begin
            grant_o[GNT_IC_RD] = 1'b1;
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Single-port main-memory arbiter between IC fills and DC fills/writebacks.
// One transaction at a time; every output is driven from registers.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_rd_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_done_o,
    output logic [LINE_W-1:0]    ic_line_o,
    input  logic                 dc_rd_i,
    input  logic                 dc_wr_i,
    input  logic [ADDR_SIZE-1:0] dc_rd_addr_i,
    input  logic [ADDR_SIZE-1:0] dc_wr_addr_i,
    input  logic [LINE_W-1:0]    dc_wr_line_i,
    output logic                 dc_rd_done_o,
    output logic                 dc_wr_done_o,
    output logic [LINE_W-1:0]    dc_line_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LINE_W-1:0]    mem_line_o,
    input  logic                 mem_ready_i,
    input  logic [LINE_W-1:0]    mem_line_i,
    output logic                 arb_busy_o
);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]    wline_q, wline_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [LINE_W-1:0]    ic_line_q, ic_line_d;
    logic [LINE_W-1:0]    dc_line_q, dc_line_d;
    logic [2:0]           grant;
    logic                 any_req;

    assign any_req = ic_rd_i | dc_rd_i | dc_wr_i;

    segre_arb_picker #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_picker (
        .ic_rd_i      (ic_rd_i),
        .dc_rd_i      (dc_rd_i),
        .dc_wr_i      (dc_wr_i),
        .starve_cnt_i (starve_q),
        .grant_o      (grant)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (any_req)     state_d = ARB_BUSY;
            ARB_BUSY: if (mem_ready_i) state_d = ARB_RESP;
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        starve_d  = starve_q;
        ic_line_d = ic_line_q;
        dc_line_d = dc_line_q;
        if (state_q == ARB_IDLE && any_req) begin
            unique case (1'b1)
                grant[GNT_DC_WR]: begin
                    owner_d = OWN_DC_WR;
                    addr_d  = dc_wr_addr_i;
                    wline_d = dc_wr_line_i;
                end
                grant[GNT_DC_RD]: begin
                    owner_d = OWN_DC_RD;
                    addr_d  = dc_rd_addr_i;
                end
                default: begin
                    owner_d = OWN_IC_RD;
                    addr_d  = ic_addr_i;
                end
            endcase
            starve_d = starve_next(starve_q, grant[GNT_IC_RD], ic_rd_i,
                                   STARVE_W'(STARVE_LIMIT));
        end
        // Fill data is captured once; the line registers hold until the next fill.
        if (state_q == ARB_BUSY && mem_ready_i) begin
            if (owner_q == OWN_IC_RD) ic_line_d = mem_line_i;
            if (owner_q == OWN_DC_RD) dc_line_d = mem_line_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q   <= OWN_IC_RD;
            addr_q    <= '0;
            wline_q   <= '0;
            starve_q  <= '0;
            ic_line_q <= '0;
            dc_line_q <= '0;
        end else begin
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wline_q   <= wline_d;
            starve_q  <= starve_d;
            ic_line_q <= ic_line_d;
            dc_line_q <= dc_line_d;
        end
    end

    always_comb begin
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        ic_done_o    = 1'b0;
        dc_rd_done_o = 1'b0;
        dc_wr_done_o = 1'b0;
        arb_busy_o   = 1'b0;
        unique case (state_q)
            ARB_BUSY: begin
                mem_rd_o   = (owner_q != OWN_DC_WR);
                mem_wr_o   = (owner_q == OWN_DC_WR);
                arb_busy_o = 1'b1;
            end
            ARB_RESP: begin
                ic_done_o    = (owner_q == OWN_IC_RD);
                dc_rd_done_o = (owner_q == OWN_DC_RD);
                dc_wr_done_o = (owner_q == OWN_DC_WR);
                arb_busy_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr_o = addr_q;
    assign mem_line_o = wline_q;
    assign ic_line_o  = ic_line_q;
    assign dc_line_o  = dc_line_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: vector table, directed corner cases,
// and random traffic against a memory model and arbitration reference.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    localparam int LIMIT = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ic_rd, dc_rd, dc_wr, mem_ready;
    logic [ADDR_SIZE-1:0] ic_addr, dc_rd_addr, dc_wr_addr;
    logic [LINE_W-1:0]    dc_wr_line, mem_line;
    logic                 ic_done_o, dc_rd_done_o, dc_wr_done_o;
    logic                 mem_rd_o, mem_wr_o, arb_busy_o;
    logic [ADDR_SIZE-1:0] mem_addr_o;
    logic [LINE_W-1:0]    ic_line_o, dc_line_o, mem_line_o;

    always #5 clk = ~clk;

    segre_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .ic_rd_i(ic_rd), .ic_addr_i(ic_addr),
        .ic_done_o(ic_done_o), .ic_line_o(ic_line_o),
        .dc_rd_i(dc_rd), .dc_wr_i(dc_wr),
        .dc_rd_addr_i(dc_rd_addr), .dc_wr_addr_i(dc_wr_addr),
        .dc_wr_line_i(dc_wr_line),
        .dc_rd_done_o(dc_rd_done_o), .dc_wr_done_o(dc_wr_done_o),
        .dc_line_o(dc_line_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_addr_o(mem_addr_o), .mem_line_o(mem_line_o),
        .mem_ready_i(mem_ready), .mem_line_i(mem_line),
        .arb_busy_o(arb_busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [LINE_W-1:0] a,
                       input logic [LINE_W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    logic [LINE_W-1:0] mem_arr [logic [ADDR_SIZE-1:0]];
    logic [LINE_W-1:0] ref_arr [logic [ADDR_SIZE-1:0]];

    function automatic logic [LINE_W-1:0] pat(input logic [ADDR_SIZE-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234};
    endfunction

    function automatic logic [LINE_W-1:0] mem_rd(input logic [ADDR_SIZE-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : pat(a);
    endfunction

    function automatic logic [LINE_W-1:0] ref_rd(input logic [ADDR_SIZE-1:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : pat(a);
    endfunction

    bit mem_auto;
    int lat_fixed, lat_cur, mcnt;

    // Memory answers after lat_cur cycles of command (random if lat_fixed==0).
    task automatic mem_tick();
        if (!mem_auto) return;
        if (mem_rd_o || mem_wr_o) begin
            if (mcnt == 0)
                lat_cur = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            mcnt++;
            if (mcnt == lat_cur) begin
                mem_ready = 1'b1;
                if (mem_wr_o) mem_arr[mem_addr_o] = mem_line_o;
                else          mem_line = mem_rd(mem_addr_o);
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mem_ready = 1'b0;
            mcnt = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mem_tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ic_rd = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
        mem_ready = 1'b0; mcnt = 0;
        mem_arr.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic ic, dr, dw;
        int   lat;
        logic exp_rd, exp_wr;
        logic [ADDR_SIZE-1:0] exp_addr;
        int   exp_done;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n, rdh, dcn, ecnt, expo, acto, dv;
        bit bad, wr_seen, rd_seen, pb;
        bit p_ic, p_dr, p_dw;
        logic [ADDR_SIZE-1:0] p_ica, p_dra, lat_addr;
        logic [LINE_W-1:0] p_dwl, saved;
        string seq;

        ic_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0;
        dc_wr_line = '0; mem_line = '0;
        mem_auto = 1'b1; lat_fixed = 1;

        vt[0] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h1000, 0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 32'h3000, 1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 32'h2000, 2};
        vt[3] = '{1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1, 32'h2000, 2};
        vt[4] = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 32'h3000, 1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 32'h2000, 2};
        vt[6] = '{1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b1, 32'h2000, 2};

        do_reset();
        chki("reset busy", int'(arb_busy_o), 0);
        chki("reset mem_rd", int'(mem_rd_o), 0);
        chk("reset ic_line", ic_line_o, '0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            mem_auto = 1'b1; lat_fixed = vt[i].lat;
            ic_addr = 32'h1000; dc_rd_addr = 32'h3000; dc_wr_addr = 32'h2000;
            dc_wr_line = pat(32'hBEEF_0000 + i);
            ic_rd = vt[i].ic; dc_rd = vt[i].dr; dc_wr = vt[i].dw;
            step();
            chki($sformatf("vec%0d mem_rd", i), int'(mem_rd_o), int'(vt[i].exp_rd));
            chki($sformatf("vec%0d mem_wr", i), int'(mem_wr_o), int'(vt[i].exp_wr));
            chk($sformatf("vec%0d addr", i), LINE_W'(mem_addr_o), LINE_W'(vt[i].exp_addr));
            n = 1;
            while (!(ic_done_o | dc_rd_done_o | dc_wr_done_o) && n < 20) begin
                step(); n++;
            end
            dv = int'({dc_wr_done_o, dc_rd_done_o, ic_done_o});
            chki($sformatf("vec%0d done", i), dv, 1 << vt[i].exp_done);
            chki($sformatf("vec%0d latency", i), n, vt[i].lat + 1);
            ic_rd = 1'b0; dc_rd = 1'b0; dc_wr = 1'b0;
            step();
        end

        // Single IC fill, memory latency 3
        do_reset();
        lat_fixed = 3; ic_addr = 32'h100; ic_rd = 1'b1;
        n = 0; rdh = 0;
        do begin
            step(); n++;
            if (mem_rd_o && mem_addr_o == 32'h100) rdh++;
        end while (!ic_done_o && n < 20);
        chki("t1 done cycle", n, 4);
        chki("t1 rd cycles", rdh, 3);
        chk("t1 ic_line", ic_line_o, pat(32'h100));
        ic_rd = 1'b0;
        step();
        chki("t1 done width", int'(ic_done_o), 0);

        // Evict + fill: writeback completes before fill starts
        do_reset();
        lat_fixed = 2;
        dc_wr_addr = 32'h2000; dc_rd_addr = 32'h3000;
        dc_wr_line = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        dc_wr = 1'b1; dc_rd = 1'b1;
        bad = 0; wr_seen = 0; rd_seen = 0;
        for (int k = 0; k < 40 && !rd_seen; k++) begin
            step();
            if (mem_rd_o && !wr_seen) bad = 1;
            if (dc_wr_done_o) begin wr_seen = 1; dc_wr = 1'b0; end
            if (dc_rd_done_o) begin rd_seen = 1; dc_rd = 1'b0; end
        end
        chki("t2 fill before wb done", int'(bad), 0);
        chki("t2 fill done", int'(rd_seen), 1);
        chk("t2 wb data", mem_rd(32'h2000), 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        chk("t2 dc_line", dc_line_o, pat(32'h3000));

        // Starvation: IC held while DC issues 6 back-to-back fills
        do_reset();
        lat_fixed = 1; ic_addr = 32'h140; ic_rd = 1'b1;
        dc_rd_addr = 32'h3000; dc_rd = 1'b1;
        dcn = 0; pb = 0; seq = ""; n = 0;
        while ((dcn < 6 || ic_rd) && n < 200) begin
            step(); n++;
            if (arb_busy_o && !pb) begin
                seq = {seq, (mem_addr_o == ic_addr) ? "I" : "D"};
                if (mem_addr_o == ic_addr)
                    chki("t3 starve_cnt after IC", int'(dut.starve_q), 0);
            end
            pb = arb_busy_o;
            if (ic_done_o) ic_rd = 1'b0;
            if (dc_rd_done_o) begin
                dcn++;
                if (dcn == 6) dc_rd = 1'b0;
                else dc_rd_addr = dc_rd_addr + 32'h10;
            end
        end
        checks++;
        if (seq != "DDDDIDD") begin
            errors++;
            $display("FAIL t3 grant order: got %s expected DDDDIDD", seq);
        end

        // Spurious ready in RESP and IDLE
        do_reset();
        mem_auto = 1'b0; ic_addr = 32'h180; ic_rd = 1'b1;
        step();
        mem_line = pat(32'h180); mem_ready = 1'b1;
        step();
        chki("t4 done in resp", int'(ic_done_o), 1);
        mem_line = '1; ic_rd = 1'b0;
        step();
        chki("t4 idle after resp", int'(arb_busy_o), 0);
        chki("t4 no extra done", int'(ic_done_o), 0);
        chk("t4 line after resp ready", ic_line_o, pat(32'h180));
        step();
        chki("t4 idle ready busy", int'(arb_busy_o | mem_rd_o), 0);
        chki("t4 idle ready done", int'(ic_done_o | dc_rd_done_o | dc_wr_done_o), 0);
        chk("t4 line after idle ready", ic_line_o, pat(32'h180));
        saved = dc_line_o;
        chk("t4 dc_line unchanged", saved, '0);
        mem_ready = 1'b0;

        // Asynchronous reset in the middle of BUSY
        mem_auto = 1'b1; lat_fixed = 6; mcnt = 0;
        ic_addr = 32'h1C0; ic_rd = 1'b1;
        step(); step();
        chki("t5 busy before rst", int'(mem_rd_o), 1);
        #2 rst = 1'b1;
        #1;
        chki("t5 rst busy", int'(arb_busy_o), 0);
        chki("t5 rst mem_rd", int'(mem_rd_o), 0);
        chk("t5 rst addr", LINE_W'(mem_addr_o), '0);
        chk("t5 rst ic_line", ic_line_o, '0);
        mem_ready = 1'b0; mcnt = 0; mem_arr.delete();
        @(negedge clk) rst = 1'b0;
        n = 0;
        do begin step(); n++; end while (!ic_done_o && n < 20);
        chki("t5 regrant done", int'(ic_done_o), 1);
        chk("t5 regrant line", ic_line_o, pat(32'h1C0));
        ic_rd = 1'b0;
        step();

        // Back-to-back: DC fill then IC with a single IDLE cycle
        do_reset();
        lat_fixed = 2; ic_addr = 32'h1200; dc_rd_addr = 32'h3100;
        ic_rd = 1'b1; dc_rd = 1'b1;
        step();
        chk("t6 first owner", LINE_W'(mem_addr_o), LINE_W'(32'h3100));
        n = 0;
        while (!dc_rd_done_o && n < 20) begin step(); n++; end
        chki("t6 dc done", int'(dc_rd_done_o), 1);
        dc_rd = 1'b0;
        step();
        chki("t6 idle gap", int'(arb_busy_o), 0);
        step();
        chki("t6 ic granted", int'(mem_rd_o), 1);
        chk("t6 ic addr", LINE_W'(mem_addr_o), LINE_W'(32'h1200));
        n = 0;
        while (!ic_done_o && n < 20) begin step(); n++; end
        ic_rd = 1'b0;

        // Random traffic against the reference
        do_reset();
        ref_arr.delete();
        lat_fixed = 0; ecnt = 0; pb = 0; expo = 0;
        p_ic = 0; p_dr = 0; p_dw = 0;
        p_ica = '0; p_dra = '0; p_dwl = '0; lat_addr = '0;
        for (int c = 0; c < 3300; c++) begin
            step();
            if (arb_busy_o && !pb) begin
                if (p_ic && ecnt >= LIMIT) expo = 0;
                else if (p_dw)             expo = 2;
                else if (p_dr)             expo = 1;
                else                       expo = 0;
                if (mem_wr_o)                   acto = 2;
                else if (mem_addr_o == p_ica)   acto = 0;
                else if (mem_addr_o == p_dra)   acto = 1;
                else                            acto = 3;
                chki("rnd grant owner", acto, expo);
                if (acto == 2) chk("rnd wb line", mem_line_o, p_dwl);
                if (expo == 0)  ecnt = 0;
                else if (p_ic)  ecnt = (ecnt + 1 > LIMIT) ? LIMIT : ecnt + 1;
                else            ecnt = 0;
                lat_addr = mem_addr_o;
            end
            if (mem_rd_o || mem_wr_o)
                chk("rnd addr stable", LINE_W'(mem_addr_o), LINE_W'(lat_addr));
            dv = int'({dc_wr_done_o, dc_rd_done_o, ic_done_o});
            if (dv != 0) chki("rnd done owner", dv, 1 << expo);
            if (ic_done_o) begin
                chk("rnd ic_line", ic_line_o, pat(ic_addr));
                ic_rd = 1'b0;
            end
            if (dc_rd_done_o) begin
                chk("rnd dc_line", dc_line_o, ref_rd(dc_rd_addr));
                dc_rd = 1'b0;
            end
            if (dc_wr_done_o) begin
                ref_arr[dc_wr_addr] = dc_wr_line;
                dc_wr = 1'b0;
            end
            if (c < 3000) begin
                if (!ic_rd && $urandom_range(0, 3) == 0) begin
                    ic_rd = 1'b1;
                    ic_addr = 32'h1000 + 32'h10 * $urandom_range(0, 15);
                end
                if (!dc_rd && $urandom_range(0, 2) == 0) begin
                    dc_rd = 1'b1;
                    dc_rd_addr = 32'h2000 + 32'h10 * $urandom_range(0, 7);
                end
                if (!dc_wr && $urandom_range(0, 3) == 0) begin
                    dc_wr = 1'b1;
                    dc_wr_addr = 32'h2000 + 32'h10 * $urandom_range(0, 7);
                    dc_wr_line = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
            end
            p_ic = ic_rd; p_dr = dc_rd; p_dw = dc_wr;
            p_ica = ic_addr; p_dra = dc_rd_addr; p_dwl = dc_wr_line;
            pb = arb_busy_o;
        end
        chki("rnd all requests served", int'({ic_rd, dc_rd, dc_wr}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

Arbitrates the single main-memory port between instruction-cache line fills and data-cache line fills and dirty-line writebacks. Sits between `segre_cache` (ICACHE and DCACHE instances) and the memory model. It is one transaction at a time, with registered request and response paths. Data-cache traffic has priority, and a bounded starvation counter protects instruction fetch.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive DC grants allowed while an IC request waits; legal range 1..15.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `ic_rd_i` in 1: IC line-fill request, level; held until `ic_done_o`.
- `ic_addr_i` in ADDR_SIZE: IC line address.
- `ic_done_o` out 1: one-cycle pulse; `ic_line_o` valid.
- `ic_line_o` out CACHE_LINE_SIZE_BYTES×8: fill data to IC.
- `dc_rd_i` in 1: DC line-fill request, level.
- `dc_wr_i` in 1: DC writeback request, level.
- `dc_rd_addr_i` / `dc_wr_addr_i` in ADDR_SIZE: fill and writeback line addresses.
- `dc_wr_line_i` in CACHE_LINE_SIZE_BYTES×8: dirty line to write back.
- `dc_rd_done_o` / `dc_wr_done_o` out 1: one-cycle completion pulses.
- `dc_line_o` out CACHE_LINE_SIZE_BYTES×8: fill data to DC.
- `mem_rd_o` / `mem_wr_o` out 1: memory command, held until `mem_ready_i`.
- `mem_addr_o` out ADDR_SIZE: line address to memory.
- `mem_line_o` out CACHE_LINE_SIZE_BYTES×8: write data.
- `mem_ready_i` in 1: memory completion; fill data valid on `mem_line_i`.
- `mem_line_i` in CACHE_LINE_SIZE_BYTES×8: read line.
- `arb_busy_o` out 1: high in BUSY and RESP; used for pipeline stall logic.

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE → BUSY when any request is high.
  - BUSY → RESP on `mem_ready_i`.
  - RESP → IDLE unconditionally.
- Arbitration is evaluated only in IDLE. Priority order:
  - `dc_wr_i` first.
  - Then `dc_rd_i`.
  - Then `ic_rd_i`.
  - Exception: when `starve_cnt == STARVE_LIMIT` and `ic_rd_i` is high, IC wins.
- Writeback before fill: if `dc_wr_i` and `dc_rd_i` are both high, the writeback is served first, then the fill is served in a later arbitration.
- Grant latches into registers: owner (IC_RD, DC_RD, DC_WR), address, and for DC_WR the write line. Memory outputs are driven only from these registers.
- `starve_cnt`:
  - Increments on each DC grant while `ic_rd_i` is high, saturating at `STARVE_LIMIT`.
  - Clears on an IC grant.
  - Clears on a DC grant while `ic_rd_i` is low.
- On `mem_ready_i` in BUSY:
  - An IC_RD owner captures `mem_line_i` into `ic_line_o`.
  - A DC_RD owner captures it into `dc_line_o`.
  - The line registers hold their value until the next capture.
- RESP: the owner's done pulse is high for exactly this cycle.
- `mem_ready_i` outside BUSY is ignored; no state change, no pulse.
- Requests arriving while BUSY or RESP wait. Requesters hold their level, and no request is lost.
- Reset, including mid-transaction:
  - State returns to IDLE; the in-flight transaction is abandoned.
  - Cleared to 0: `starve_cnt`, all `*_o` outputs, and the line registers.
  - The memory model is reset by the same `rst_i`.

## Timing
- Request sampled in IDLE at cycle N → `mem_rd_o`/`mem_wr_o` high from N+1.
- `mem_ready_i` at cycle M ≥ N+1 → RESP and done pulse at M+1 → IDLE at M+2.
- Minimum request-to-done is 2 cycles; the arbiter adds 2 cycles of overhead beyond memory latency.
- The requester drops its request on the edge after seeing done. IDLE at M+2 must not re-grant a stale request. Because done outputs are registered, a registered requester satisfies this.
- `mem_addr_o` and `mem_line_o` are stable throughout BUSY.
- No combinational path from any input to any output.

## Structure
- `segre_pkg` gets:
  - `arb_state_e` {ARB_IDLE, ARB_BUSY, ARB_RESP}.
  - `arb_owner_e` {OWN_IC_RD, OWN_DC_RD, OWN_DC_WR}.
  - Existing ADDR_SIZE and CACHE_LINE_SIZE_BYTES are reused.
- Sub-module `segre_arb_picker`: combinational priority selection plus the starvation override. Its inputs are the three requests and `starve_cnt`; its output is a one-hot grant.
- The top holds the FSM, the latches, `starve_cnt` and the line registers.

## Test plan
- Single IC fill: `ic_rd_i`=1, addr 0x100, memory latency 3 → `mem_rd_o` high 3 cycles with addr 0x100, `ic_done_o` pulses 4 cycles after request, `ic_line_o` = memory line.
- Evict+fill: `dc_wr_i`=`dc_rd_i`=1 (wr 0x2000, rd 0x3000) → writeback to 0x2000 completes (`dc_wr_done_o`) before `mem_rd_o` asserts for 0x3000.
- Starvation: `ic_rd_i` held, DC issues 6 back-to-back fills, `STARVE_LIMIT`=4 → grants are DC×4, IC, DC×2; `starve_cnt` returns to 0 after the IC grant.
- Spurious ready: `mem_ready_i` pulsed in IDLE and in RESP → no state change, no done pulse, line registers unchanged.
- Reset mid-transaction: `rst_i` asserted asynchronously mid-BUSY → immediately all outputs 0 and `arb_busy_o`=0; after release, a pending `ic_rd_i` is granted normally.
- Back-to-back: IC and DC read requests both high → DC done, then IC granted in the IDLE cycle right after RESP; no dead cycles beyond IDLE.
